mod_reduce_sched: RTL and testbench

MOD_REDUCE_SCHED -- requirements
Module: mod_reduce_sched

---
 rtl/mod_reduce_sched.sv | 148 ++++++++++++++
 tb/tb_mod_reduce_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_reduce_sched.sv
// Round-robin scheduler sharing one modular-reduction engine among N_REQ requesters.
// Latency: grant at T, eng_start at T+1, rsp_valid at T+2+L (L = engine latency); Q=0 answers at T+1.
// Backpressure: a held response (rsp_ready low) parks the FSM in RESP; no grant or engine start until the handshake.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready/req_data      per-requester operand handshake (ready is combinational, IDLE only)
//   cfg_q                             modulus, captured at grant
//   eng_start/eng_data_in/eng_q       command to the shared reducer (operands held while in flight)
//   eng_done/eng_data_out             reducer completion and result (only honoured in WAIT)
//   rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err   response channel
//   err_timeout                       sticky flag, set when the reducer fails to answer in time
//   busy                              FSM is not IDLE
module mod_reduce_sched #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int Q_WIDTH    = 23,
    parameter int TIMEOUT    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [Q_WIDTH-1:0]          cfg_q,
    output logic                        eng_start,
    output logic [DATA_WIDTH-1:0]       eng_data_in,
    output logic [Q_WIDTH-1:0]          eng_q,
    input  logic                        eng_done,
    input  logic [Q_WIDTH-1:0]          eng_data_out,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [$clog2(N_REQ)-1:0]    rsp_id,
    output logic [Q_WIDTH-1:0]          rsp_data,
    output logic                        rsp_err,
    output logic                        err_timeout,
    output logic                        busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  wait_cnt;

    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    int             scan_idx;

    // First asserted request at or above rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = (int'(rr_ptr) + i) % N_REQ;
            if (!gnt_found && req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(scan_idx);
            end
        end
    end

    // Ready is only offered from IDLE, and never while reset is being applied.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && gnt_found && !rst) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            rr_ptr      <= '0;
            wait_cnt    <= '0;
            eng_start   <= 1'b0;
            eng_data_in <= '0;
            eng_q       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (gnt_found) begin
                        eng_data_in <= req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                        eng_q       <= cfg_q;
                        rsp_id      <= gnt_idx;
                        if (cfg_q == '0) begin
                            // A zero modulus is meaningless: answer with an error without touching the engine.
                            rsp_data  <= '0;
                            rsp_err   <= 1'b1;
                            rsp_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            eng_start <= 1'b1;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    // eng_done takes priority over a timeout expiring in the same cycle.
                    if (eng_done) begin
                        rsp_data  <= eng_data_out;
                        rsp_err   <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= S_RESP;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        rsp_data    <= '0;
                        rsp_err     <= 1'b1;
                        rsp_valid   <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (rsp_id == IDW'(N_REQ - 1)) ? '0 : rsp_id + 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce_sched.sv
// Self-checking bench for mod_reduce_sched: directed vector table, corner-case sequences, randomized scoreboard run.
// Latency: the reducer model answers L cycles after eng_start with eng_data_in mod eng_q.
// Backpressure: rsp_ready is driven low in directed and random phases to hold responses.
module tb_mod_reduce_sched;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int QW = 23;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data = '0;
    logic [QW-1:0]   cfg_q = '0;
    logic            eng_start;
    logic [DW-1:0]   eng_data_in;
    logic [QW-1:0]   eng_q;
    logic            eng_done;
    logic [QW-1:0]   eng_data_out;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [1:0]      rsp_id;
    logic [QW-1:0]   rsp_data;
    logic            rsp_err;
    logic            err_timeout;
    logic            busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mod_reduce_sched #(.N_REQ(N), .DATA_WIDTH(DW), .Q_WIDTH(QW), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .cfg_q(cfg_q),
        .eng_start(eng_start), .eng_data_in(eng_data_in), .eng_q(eng_q),
        .eng_done(eng_done), .eng_data_out(eng_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .err_timeout(err_timeout), .busy(busy)
    );

    // Reducer model: answers eng_lat cycles after eng_start unless eng_never is set.
    int          eng_lat     = 2;
    bit          eng_never   = 1'b0;
    int          eng_rem     = 0;
    logic        model_done  = 1'b0;
    logic        manual_done = 1'b0;
    logic [QW-1:0] eng_res   = '0;

    assign eng_done     = model_done | manual_done;
    assign eng_data_out = manual_done ? 23'h1234 : eng_res;

    always @(negedge clk) begin
        logic [DW-1:0] r;
        model_done = 1'b0;
        if (rst) begin
            eng_rem = 0;
        end else begin
            if (eng_rem > 0) begin
                eng_rem--;
                if (eng_rem == 0) begin
                    model_done = 1'b1;
                    r = (eng_q != '0) ? eng_data_in % {9'd0, eng_q} : '0;
                    eng_res = r[QW-1:0];
                end
            end
            if (eng_start === 1'b1 && !eng_never) eng_rem = eng_lat;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; manual_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ctrl"}, {req_ready, eng_start, rsp_valid, rsp_id, rsp_err, err_timeout, busy}, '0);
        check({tag, "_data"}, {rsp_data, eng_q}, '0);
        check({tag, "_eng_data_in"}, eng_data_in, '0);
    endtask

    // Wait until the block is idle with no response pending, draining responses.
    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            req_valid = '0; rsp_ready = 1'b1;
            #1;
            if (!busy && !rsp_valid) done = 1'b1;
        end
        check({tag, "_idle"}, done, 1'b1);
    endtask

    function automatic int pick(input int p, input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (p + k) % N;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    typedef struct {
        logic [N-1:0]  mask;
        logic [DW-1:0] data;
        logic [QW-1:0] q;
        int            lat;
        logic [N-1:0]  exp_ready;
        logic [1:0]    exp_id;
        logic [QW-1:0] exp_data;
        logic          exp_err;
        int            exp_starts;
        int            exp_cyc;     // first rsp_valid cycle after grant; -1 = not checked
    } vec_t;

    // One request from an idle block; cfg_q is disturbed after the grant to prove it was latched.
    task automatic run_vec(input string tag, input vec_t v);
        int starts = 0;
        int cyc    = 0;
        bit got    = 1'b0;
        @(negedge clk);
        eng_lat = v.lat; req_valid = v.mask; cfg_q = v.q; rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = v.data;
        #1;
        check({tag, "_grant"}, req_ready, v.exp_ready);
        for (int c = 1; c < 200 && !got; c++) begin
            @(negedge clk);
            req_valid = '0; cfg_q = 23'h2AAAAA;
            #1;
            if (eng_start) starts++;
            if (rsp_valid) begin
                got = 1'b1; cyc = c;
                check({tag, "_rsp_id"}, rsp_id, v.exp_id);
                check({tag, "_rsp_data"}, rsp_data, v.exp_data);
                check({tag, "_rsp_err"}, rsp_err, v.exp_err);
            end
        end
        check({tag, "_rsp_seen"}, got, 1'b1);
        check({tag, "_eng_starts"}, starts, v.exp_starts);
        if (v.exp_cyc >= 0) check({tag, "_rsp_cycle"}, cyc, v.exp_cyc);
        @(negedge clk);
        #1;
        check({tag, "_back_idle"}, {rsp_valid, busy}, 2'b00);
    endtask

    vec_t vecs[6];

    initial begin
        int   grants[$];
        int   cnt;
        bit   got;
        vec_t v;

        vecs[0] = '{4'b0001, 32'd8380418,    23'd8380417, 3, 4'b0001, 2'd0, 23'd1,       1'b0, 1, 5};
        vecs[1] = '{4'b0010, 32'd12345,      23'd0,       2, 4'b0010, 2'd1, 23'd0,       1'b1, 0, -1};
        vecs[2] = '{4'b1110, 32'd100,        23'd7,       1, 4'b0100, 2'd2, 23'd2,       1'b0, 1, 3};
        vecs[3] = '{4'b1001, 32'hFFFF_FFFF,  23'd8380417, 5, 4'b1000, 2'd3, 23'd4193791, 1'b0, 1, 7};
        vecs[4] = '{4'b0011, 32'd5,          23'd8388607, 2, 4'b0001, 2'd0, 23'd5,       1'b0, 1, 4};
        vecs[5] = '{4'b0101, 32'd1000,       23'd1000,    4, 4'b0100, 2'd2, 23'd0,       1'b0, 1, 6};

        // Reset state.
        do_reset();
        #1;
        check_reset_state("reset");

        // Directed table; the Q=0 entry leaves rr_ptr at 2, which entry 2 relies on.
        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Fairness with every requester asserting from a fresh pointer.
        do_reset();
        eng_lat = 2;
        for (int c = 0; c < 200 && grants.size() < 6; c++) begin
            @(negedge clk);
            req_valid = 4'hF; rsp_ready = 1'b1; cfg_q = 23'd97;
            #1;
            for (int i = 0; i < N; i++) if (req_ready[i]) grants.push_back(i);
        end
        check("fair_count", grants.size(), 6);
        for (int i = 0; i < grants.size() && i < 6; i++)
            check($sformatf("fair_order%0d", i), grants[i], i % 4);
        wait_idle("fair");

        // Backpressure: response held for 10 cycles while requester 0 keeps asking.
        @(negedge clk);
        req_valid = 4'b0001; rsp_ready = 1'b0; cfg_q = 23'd10; eng_lat = 3;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'd77;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) got = 1'b1;
        end
        check("bp_rsp_seen", got, 1'b1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            check("bp_valid_held", rsp_valid, 1'b1);
            check("bp_fields_held", {rsp_id, rsp_data, rsp_err}, {2'd0, 23'd7, 1'b0});
            check("bp_no_ready", req_ready, '0);
            check("bp_no_start", eng_start, 1'b0);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("bp_release_no_grant", req_ready, '0);
        @(negedge clk);
        #1;
        check("bp_next_grant", req_ready, 4'b0001);
        wait_idle("bp");

        // Timeout: the reducer never answers.
        eng_never = 1'b1;
        @(negedge clk);
        req_valid = 4'b0010; rsp_ready = 1'b1; cfg_q = 23'd5;
        #1;
        check("to_grant", req_ready, 4'b0010);
        check("to_flag_clear", err_timeout, 1'b0);
        got = 1'b0; cnt = 0;
        for (int c = 1; c < 200 && !got; c++) begin
            @(negedge clk);
            req_valid = '0;
            #1;
            if (rsp_valid) begin
                got = 1'b1; cnt = c;
                check("to_rsp", {rsp_id, rsp_data, rsp_err}, {2'd1, 23'd0, 1'b1});
            end
        end
        check("to_rsp_seen", got, 1'b1);
        check("to_rsp_cycle", cnt, 66);
        check("to_flag_set", err_timeout, 1'b1);
        eng_never = 1'b0;
        @(negedge clk);
        #1;
        v = '{4'b0100, 32'd50, 23'd7, 3, 4'b0100, 2'd2, 23'd1, 1'b0, 1, 5};
        run_vec("after_to", v);
        check("to_flag_sticky", err_timeout, 1'b1);

        // Reset in WAIT, then a stray eng_done.
        eng_never = 1'b1;
        @(negedge clk);
        req_valid = 4'b0001; rsp_ready = 1'b1; cfg_q = 23'd5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            req_valid = '0;
        end
        #1;
        check("rw_busy_before", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_state("rw_after");
        @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (rsp_valid || busy) cnt++;
        end
        check("rw_late_done_ignored", cnt, 0);

        // Randomized run against a scoreboard: round-robin pick plus arithmetic reduction.
        begin
            int            remaining[N];
            logic [DW-1:0] cur_data[N];
            int            model_ptr = 0;
            bit            pend = 1'b0;
            logic [1:0]    pend_id = '0;
            logic [QW-1:0] pend_data = '0;
            logic          pend_err = 1'b0;
            int            ngrants = 0;
            int            g;
            logic [DW-1:0] r;
            bit            finished = 1'b0;

            eng_never = 1'b0;
            do_reset();
            for (int i = 0; i < N; i++) begin remaining[i] = 0; cur_data[i] = $urandom; end
            for (int c = 0; c < 5000 && !finished; c++) begin
                @(negedge clk);
                if (c < 600)
                    for (int i = 0; i < N; i++)
                        if (remaining[i] == 0 && $urandom_range(0, 7) == 0) begin
                            remaining[i] = $urandom_range(1, 3);
                            cur_data[i]  = $urandom;
                        end
                for (int i = 0; i < N; i++) begin
                    req_valid[i] = (remaining[i] > 0);
                    req_data[i*DW +: DW] = cur_data[i];
                end
                cfg_q     = ($urandom_range(0, 7) == 0) ? 23'd0 : QW'($urandom_range(1, 8388607));
                rsp_ready = ($urandom_range(0, 3) != 0);
                eng_lat   = $urandom_range(1, 12);
                #1;
                check("rnd_busy", busy, pend);
                if (!pend && req_valid != '0) begin
                    g = pick(model_ptr, req_valid);
                    check("rnd_grant", req_ready, 4'b0001 << g);
                    pend    = 1'b1;
                    pend_id = 2'(g);
                    if (cfg_q == '0) begin
                        pend_err = 1'b1; pend_data = '0;
                    end else begin
                        r = cur_data[g] % {9'd0, cfg_q};
                        pend_err = 1'b0; pend_data = r[QW-1:0];
                    end
                    remaining[g]--;
                    cur_data[g] = $urandom;
                    ngrants++;
                end else begin
                    check("rnd_no_ready", req_ready, '0);
                end
                if (rsp_valid) begin
                    check("rnd_rsp_pending", pend, 1'b1);
                    check("rnd_rsp", {rsp_id, rsp_data, rsp_err}, {pend_id, pend_data, pend_err});
                    if (rsp_ready) begin
                        pend = 1'b0;
                        model_ptr = (int'(pend_id) + 1) % N;
                    end
                end
                if (c >= 600 && !pend && remaining[0] == 0 && remaining[1] == 0 &&
                    remaining[2] == 0 && remaining[3] == 0)
                    finished = 1'b1;
            end
            check("rnd_drained", finished, 1'b1);
            check("rnd_activity", ngrants > 20, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
